barrel_shift_left: RTL and testbench

Registered 25-bit logical left barrel shifter for the floating-point adder datapath. It shifts a 25-bit mantissa (hidden bit, 23 fraction bits, one guard/carry bit) left by a 5-bit amount in a single combinational log-shifter. It registers the result, so the normalization step after mantissa addition sees it one clock later. It pairs with the right-shift counterpart used for exponent alignment.

---
 rtl/barrel_shift_left_pkg.sv | 10 +
 rtl/barrel_shift_left_if.sv | 29 ++
 rtl/barrel_shift_left_mux2.sv | 11 +
 rtl/barrel_shift_left.sv | 55 +++++
 tb/tb_barrel_shift_left.sv | 131 +++++++++++++
 5 files changed

// File: rtl/barrel_shift_left_pkg.sv
// Shared FP-adder datapath constants for the mantissa shifters.
// One hidden bit, 23 fraction bits and one guard/carry bit make up the mantissa.
package barrel_shift_left_pkg;

  localparam int MANT_W  = 25;
  localparam int SHIFT_W = 5;

  localparam logic [MANT_W-1:0] MANT_ZERO = '0;

endpackage

// File: rtl/barrel_shift_left_if.sv
// Operand/result bundle between the mantissa adder and the normalization left shifter.
interface barrel_shift_left_if #(
  parameter int WIDTH   = barrel_shift_left_pkg::MANT_W,
  parameter int SHIFT_W = barrel_shift_left_pkg::SHIFT_W
);

  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [SHIFT_W-1:0] sm;
  logic [WIDTH-1:0]   out;
  logic               out_valid;

  modport master (
    output in_valid,
    output a,
    output sm,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  sm,
    output out,
    output out_valid
  );

endinterface

// File: rtl/barrel_shift_left_mux2.sv
// Single-bit 2:1 mux, the cell each log-shifter stage is built from.
module barrel_shift_left_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/barrel_shift_left.sv
// Registered logical left barrel shifter: SHIFT_W cascaded mux rows (1, 2, 4, ...)
// feeding a single output register, one operand accepted per cycle.
module barrel_shift_left #(
  parameter int WIDTH   = barrel_shift_left_pkg::MANT_W,
  parameter int SHIFT_W = barrel_shift_left_pkg::SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  barrel_shift_left_if.slave   bus
);

  import barrel_shift_left_pkg::*;

  // stage[k] is the operand after the shifts selected by sm[k-1:0]
  logic [WIDTH-1:0] stage [0:SHIFT_W];
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;

  assign stage[0] = bus.a;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int DIST = 1 << k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic shifted;
      if (i >= DIST) begin : g_src
        assign shifted = stage[k][i-DIST];
      end else begin : g_zero
        assign shifted = 1'b0;
      end
      barrel_shift_left_mux2 u_mux (
        .d0  (stage[k][i]),
        .d1  (shifted),
        .sel (bus.sm[k]),
        .y   (stage[k+1][i])
      );
    end
  end

  // out keeps its last value on idle cycles; only out_valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= WIDTH'(MANT_ZERO);
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= stage[SHIFT_W];
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shift_left.sv
// Self-checking bench for barrel_shift_left: vector table, sweeps, resets and random traffic.
module tb_barrel_shift_left;

  localparam int W = 25;
  localparam int S = 5;
  localparam logic [W-1:0] MASK = 25'h1FFFFFF;

  typedef struct {
    logic [W-1:0] a;
    logic [S-1:0] sm;
    logic [W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst;

  barrel_shift_left_if #(.WIDTH(W), .SHIFT_W(S)) bus ();

  barrel_shift_left #(.WIDTH(W), .SHIFT_W(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] model_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the expected result enters the scoreboard when the operand is driven.
  task automatic step(input logic r, input logic v, input logic [W-1:0] av,
                      input logic [S-1:0] sv, input logic [W-1:0] exp, input string tag);
    logic [W-1:0] e;
    rst          = r;
    bus.in_valid = v;
    bus.a        = av;
    bus.sm       = sv;
    if (!r && v) sb.push_back(exp);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      model_out = '0;
    end
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, (!r && v)});
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.scoreboard: got out_valid=1 expected no pending result", tag);
      end else begin
        e = sb.pop_front();
        model_out = e;
        chk({tag, ".out"}, {7'd0, bus.out}, {7'd0, e});
      end
    end else begin
      chk({tag, ".out_hold"}, {7'd0, bus.out}, {7'd0, model_out});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [8];
    logic [W-1:0] ra;
    logic [S-1:0] rs;
    logic         rv;

    vt[0] = '{25'b0101111111101010111111101, 5'd2,  25'b0111111110101011111110100};
    vt[1] = '{25'h1FFFFFF, 5'd16, 25'h1FF0000};
    vt[2] = '{25'h1FFFFFF, 5'd25, 25'h0000000};
    vt[3] = '{25'h1FFFFFF, 5'd31, 25'h0000000};
    vt[4] = '{25'h1234567, 5'd0,  25'h1234567};
    vt[5] = '{25'h1234567, 5'd1,  25'h0468ACE};
    vt[6] = '{25'h0ABCDEF, 5'd4,  25'h0BCDEF0};
    vt[7] = '{25'h1FFFFFF, 5'd24, 25'h1000000};

    // reset held two cycles with a valid operand present
    step(1'b1, 1'b1, 25'h1FFFFFF, 5'd0, '0, "rst0");
    chk("rst0.out_zero", {7'd0, bus.out}, 32'd0);
    step(1'b1, 1'b1, 25'h1FFFFFF, 5'd0, '0, "rst1");
    chk("rst1.out_zero", {7'd0, bus.out}, 32'd0);
    step(1'b0, 1'b1, 25'h1FFFFFF, 5'd0, 25'h1FFFFFF, "post_rst");

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, vt[i].a, vt[i].sm, vt[i].exp, $sformatf("vec%0d", i));
    end

    // idle cycle: out must hold the last result
    step(1'b0, 1'b0, 25'h0F0F0F0, 5'd3, '0, "idle");

    for (int s = 0; s < 25; s++) begin
      step(1'b0, 1'b1, 25'h0000001, 5'(s), 25'd1 << s, $sformatf("walk%0d", s));
    end
    chk("walk.last", {7'd0, bus.out}, 32'h1000000);

    // reset mid-stream, then immediate normal operation
    step(1'b0, 1'b1, 25'h0000123, 5'd8, 25'h0012300, "pre_rst");
    step(1'b1, 1'b1, 25'h1FFFFFF, 5'd1, '0, "mid_rst");
    chk("mid_rst.out_zero", {7'd0, bus.out}, 32'd0);
    step(1'b0, 1'b1, 25'h0000ABC, 5'd12, 25'h0ABC000, "after_rst");
    step(1'b0, 1'b0, 25'h1FFFFFF, 5'd0, '0, "after_rst_idle");

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rs = S'($urandom_range(0, 31));
      rv = 1'($urandom_range(0, 1));
      step(1'b0, rv, ra, rs, (ra << rs) & MASK, "rand");
    end

    bus.in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
